serial_add_seq: RTL
===================

SERIAL_ADD_SEQ -- requirements
Module: serial_add_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits (legal range 2..16).
REQ-002 SHALL have port clk  input  1  single system clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  operands a, b, cin are valid.
REQ-005 SHALL have port in_ready  output  1  block can accept operands.
REQ-006 SHALL have port a  input  WIDTH  operand A.
REQ-007 SHALL have port b  input  WIDTH  operand B.
REQ-008 SHALL have port cin  input  1  carry-in.
REQ-009 SHALL have port out_valid  output  1  sum and cout are valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-011 SHALL have port sum  output  WIDTH  result bits, a+b+cin modulo 2^WIDTH.
REQ-012 SHALL have port cout  output  1  carry out of bit WIDTH-1.

Function
REQ-013 SHALL implement the states IDLE, RUN and DONE.
REQ-014 In IDLE, in_ready SHALL be 1 and out_valid 0; in RUN and DONE, in_ready SHALL be 0.
REQ-015 An accept edge is an edge with in_valid=1 and in_ready=1; it SHALL capture a, b and cin into shift/carry registers, clear the bit counter, clear sum, and go to RUN.
REQ-016 Each RUN edge SHALL process one bit, LSB first: s = a_i^b_i^c; c' = (a_i&b_i)|(c&(a_i^b_i)).
REQ-017 Each RUN edge SHALL shift s into sum from the MSB end.
REQ-018 RUN SHALL last exactly WIDTH edges, after which the state SHALL be DONE with out_valid=1; out_valid SHALL rise exactly WIDTH edges after the accept edge.
REQ-019 In DONE, sum and cout SHALL hold stable until an edge with out_ready=1, which SHALL return the state to IDLE.
REQ-020 An out_ready held low SHALL stall DONE indefinitely without corrupting the result.
REQ-021 in_valid SHALL be ignored outside IDLE; operands presented during RUN or DONE are not captured.
REQ-022 out_ready SHALL be ignored outside DONE.
REQ-023 Operand inputs SHALL be sampled only on the accept edge; later changes SHALL not affect the result.
REQ-024 There SHALL be no same-cycle result-to-new-operand overlap; minimum throughput is one addition per WIDTH+2 cycles.
REQ-025 The bit counter SHALL be $clog2(WIDTH+1) bits wide and SHALL not wrap within a transaction.
REQ-026 sum and cout SHALL read 0 while in IDLE until the first completed transaction; after that they SHALL hold the last result until the next accept edge clears them.

Reset
REQ-027 rst=1 at an edge SHALL force IDLE, and set in_ready=1, out_valid=0, sum=0, cout=0, counter=0 and carry register=0.
REQ-028 rst SHALL take priority over every handshake, including reset mid-RUN or in DONE; the in-flight result SHALL be discarded and not emitted.
REQ-029 The first accept edge SHALL be possible on the first edge after rst deasserts.

Structure
REQ-030 Package serial_add_pkg SHALL hold the state enum (IDLE, RUN, DONE) and the default WIDTH constant.
REQ-031 The one-bit sum/carry logic SHALL be sub-module fa_cell (inputs a, b, ci; outputs s, co), instantiated once, built from two half-adder XOR/AND stages plus an OR.
REQ-032 The design SHALL contain no combinational path from in_valid or out_ready to any output other than via registered state.

Verification
REQ-033 WIDTH=8, a=0x3C, b=0x05, cin=0 -> out_valid 8 edges after accept; sum=0x41, cout=0.
REQ-034 a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
REQ-035 out_ready held low 5 cycles in DONE -> sum and cout stable, in_ready=0 throughout; IDLE one edge after out_ready=1.
REQ-036 in_valid=1 with new operands during RUN, and a/b toggled after accept -> result equals the originally captured operands only.
REQ-037 rst=1 at the 4th RUN edge -> next cycle IDLE, out_valid=0, sum=0; a following a=0x01, b=0x01 -> sum=0x02.
REQ-038 Random back-to-back traffic with random out_ready, 1000 transactions -> every result equals a+b+cin; no lost or duplicated results.

Source files
------------

// File: rtl/serial_add_pkg.sv
// Shared types and defaults for the bit-serial adder.
package serial_add_pkg;

  localparam int WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fa_cell.sv
// One-bit full adder made from two half-adder stages plus an OR.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic hx1, hc1, hc2;

  // first half adder on the operands, second on the partial sum and carry
  always_comb begin
    hx1 = a ^ b;
    hc1 = a & b;
    s   = hx1 ^ ci;
    hc2 = hx1 & ci;
    co  = hc1 | hc2;
  end

endmodule

// File: rtl/serial_add_seq.sv
// Bit-serial adder: captures a, b and cin, adds one bit per clock LSB first,
// then presents sum/cout until the consumer takes them.
module serial_add_seq
  import serial_add_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             fa_s, fa_co;

  fa_cell u_fa (
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  // Control FSM plus datapath; every output is a flop so handshake inputs
  // only reach the outputs through registered state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      cnt       <= '0;
      carry     <= 1'b0;
      a_sh      <= '0;
      b_sh      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh     <= a;
            b_sh     <= b;
            carry    <= cin;
            cnt      <= '0;
            sum      <= '0;
            cout     <= 1'b0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          // LSB first: result bits enter at the MSB and drift down, so after
          // WIDTH edges bit 0 of sum holds bit 0 of the result.
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          carry <= fa_co;
          sum   <= {fa_s, sum[WIDTH-1:1]};
          cnt   <= cnt + CNT_W'(1);
          if (cnt == LAST) begin
            cout      <= fa_co;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
